// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter and IF/ID pipeline register with a BOOT/RUN/CACHEWAIT FSM.
// Optional misaligned-redirect trapping is enabled by defining MISALIGN_TRAP_EN.
module fetch_pc_unit #(
    parameter int               dataW        = 32,
    parameter logic [dataW-1:0] RESET_VECTOR = dataW'(32'h00000000)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             InsCacheStall,
    input  logic [dataW-1:0] FetchIns,
    input  logic             DecodeStall,
    input  logic             RedirectValid,
    input  logic [dataW-1:0] RedirectTarget,
    output logic [dataW-1:0] ProgAddr,
    output logic [dataW-1:0] IfIdIns,
    output logic [dataW-1:0] IfIdPC,
    output logic             IfIdValid,
    output logic             MisalignTrap,
    output logic [dataW-1:0] TrapAddr
);

    localparam logic [dataW-1:0] NOP     = dataW'(32'h00000013);
    localparam logic [dataW-1:0] PC_STEP = dataW'(32'd4);

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        CACHEWAIT = 2'd2
    } state_t;

    state_t           state_r;
    logic [dataW-1:0] target_s;
    logic             misaligned_s;

    // Redirect target qualification: trap on low bits, or silently word-align them.
    always_comb begin
        target_s     = RedirectTarget;
        misaligned_s = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misaligned_s = (RedirectTarget[1:0] != 2'b00);
`else
        target_s     = {RedirectTarget[dataW-1:2], 2'b00};
`endif
    end

    // FSM, program counter and IF/ID register; priority is redirect > decode stall > cache stall > advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= BOOT;
            ProgAddr  <= RESET_VECTOR;
            IfIdIns   <= NOP;
            IfIdPC    <= '0;
            IfIdValid <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    IfIdIns   <= NOP;
                    IfIdValid <= 1'b0;
                    state_r   <= RUN;
                end
                RUN, CACHEWAIT: begin
                    if (RedirectValid) begin
                        IfIdIns   <= NOP;
                        IfIdValid <= 1'b0;
                        state_r   <= RUN;
                        // A trapped redirect leaves the fetch address where it was.
                        if (!misaligned_s) begin
                            ProgAddr <= target_s;
                        end else begin
                            ProgAddr <= ProgAddr;
                        end
                    end else if (DecodeStall) begin
                        // Full hold of PC and IF/ID; the FSM still follows the cache.
                        state_r <= InsCacheStall ? CACHEWAIT : RUN;
                    end else if (InsCacheStall) begin
                        IfIdIns   <= NOP;
                        IfIdValid <= 1'b0;
                        state_r   <= CACHEWAIT;
                    end else begin
                        IfIdIns   <= FetchIns;
                        IfIdPC    <= ProgAddr;
                        IfIdValid <= 1'b1;
                        ProgAddr  <= ProgAddr + PC_STEP;
                        state_r   <= RUN;
                    end
                end
                default: begin
                    IfIdIns   <= NOP;
                    IfIdValid <= 1'b0;
                    state_r   <= BOOT;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Trap pulse and sticky faulting address, only raised outside BOOT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            MisalignTrap <= 1'b0;
            TrapAddr     <= '0;
        end else if (state_r != BOOT && RedirectValid && misaligned_s) begin
            MisalignTrap <= 1'b1;
            TrapAddr     <= RedirectTarget;
        end else begin
            MisalignTrap <= 1'b0;
        end
    end
`else
    assign MisalignTrap = 1'b0;
    assign TrapAddr     = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit (default RESET_VECTOR = 0).
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset;
    logic        InsCacheStall;
    logic [31:0] FetchIns;
    logic        DecodeStall;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic [31:0] ProgAddr;
    logic [31:0] IfIdIns;
    logic [31:0] IfIdPC;
    logic        IfIdValid;
    logic        MisalignTrap;
    logic [31:0] TrapAddr;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit dut (
        .clock          (clock),
        .reset          (reset),
        .InsCacheStall  (InsCacheStall),
        .FetchIns       (FetchIns),
        .DecodeStall    (DecodeStall),
        .RedirectValid  (RedirectValid),
        .RedirectTarget (RedirectTarget),
        .ProgAddr       (ProgAddr),
        .IfIdIns        (IfIdIns),
        .IfIdPC         (IfIdPC),
        .IfIdValid      (IfIdValid),
        .MisalignTrap   (MisalignTrap),
        .TrapAddr       (TrapAddr)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hA5A50000;
    endfunction

    // Instruction cache model: returns an address-tagged word for the current fetch address.
    assign FetchIns = tag(ProgAddr);

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_pa"},    ProgAddr, 32'h00000000);
        check({name, "_ins"},   IfIdIns, NOP);
        check({name, "_pc"},    IfIdPC, 32'h00000000);
        check({name, "_valid"}, {31'd0, IfIdValid}, 32'd0);
        check({name, "_trap"},  {31'd0, MisalignTrap}, 32'd0);
        check({name, "_taddr"}, TrapAddr, 32'h00000000);
    endtask

    initial begin
        reset          = 1'b1;
        InsCacheStall  = 1'b0;
        DecodeStall    = 1'b0;
        RedirectValid  = 1'b0;
        RedirectTarget = 32'h00000000;
        #1;
        check_reset_values("reset");
        #11;
        reset = 1'b0;

        // BOOT cycle: address held, still a bubble.
        step();
        check("boot_pa", ProgAddr, 32'h00000000);
        check("boot_valid", {31'd0, IfIdValid}, 32'd0);

        // Back-to-back fetches with one-cycle latency.
        step();
        check("adv0_pc", IfIdPC, 32'h00000000);
        check("adv0_ins", IfIdIns, tag(32'h00000000));
        check("adv0_valid", {31'd0, IfIdValid}, 32'd1);
        step();
        check("adv1_pc", IfIdPC, 32'h00000004);
        step();
        check("adv2_pc", IfIdPC, 32'h00000008);
        check("adv2_ins", IfIdIns, tag(32'h00000008));
        check("adv2_pa", ProgAddr, 32'h0000000C);

        for (int i = 0; i < 13; i++) step();
        check("pre_stall_pa", ProgAddr, 32'h00000040);
        check("pre_stall_pc", IfIdPC, 32'h0000003C);

        // Cache refill for 31 cycles at 0x40.
        InsCacheStall = 1'b1;
        for (int i = 0; i < 31; i++) begin
            step();
            check("cstall_pa", ProgAddr, 32'h00000040);
            check("cstall_valid", {31'd0, IfIdValid}, 32'd0);
        end
        InsCacheStall = 1'b0;
        step();
        check("cresume_pc", IfIdPC, 32'h00000040);
        check("cresume_ins", IfIdIns, tag(32'h00000040));
        check("cresume_valid", {31'd0, IfIdValid}, 32'd1);
        check("cresume_pa", ProgAddr, 32'h00000044);

        // Decode stall: full hold.
        DecodeStall = 1'b1;
        step();
        check("dstall_pa", ProgAddr, 32'h00000044);
        check("dstall_pc", IfIdPC, 32'h00000040);
        check("dstall_valid", {31'd0, IfIdValid}, 32'd1);

        // Redirect overrides decode stall.
        RedirectValid  = 1'b1;
        RedirectTarget = 32'h00000100;
        step();
        check("redir_pa", ProgAddr, 32'h00000100);
        check("redir_valid", {31'd0, IfIdValid}, 32'd0);
        check("redir_ins", IfIdIns, NOP);
        RedirectValid = 1'b0;
        DecodeStall   = 1'b0;
        step();
        check("redir_next_pc", IfIdPC, 32'h00000100);
        check("redir_next_valid", {31'd0, IfIdValid}, 32'd1);
        check("redir_next_pa", ProgAddr, 32'h00000104);

        // Both stalls: decode stall wins (full hold), then cache stall alone bubbles.
        DecodeStall   = 1'b1;
        InsCacheStall = 1'b1;
        step();
        check("both_pa", ProgAddr, 32'h00000104);
        check("both_pc", IfIdPC, 32'h00000100);
        check("both_valid", {31'd0, IfIdValid}, 32'd1);
        DecodeStall = 1'b0;
        step();
        check("both_bub_valid", {31'd0, IfIdValid}, 32'd0);
        check("both_bub_pa", ProgAddr, 32'h00000104);
        InsCacheStall = 1'b0;
        step();
        check("both_resume_pc", IfIdPC, 32'h00000104);

        // Address wrap.
        RedirectValid  = 1'b1;
        RedirectTarget = 32'hFFFFFFFC;
        step();
        check("wrap_redir_pa", ProgAddr, 32'hFFFFFFFC);
        RedirectValid = 1'b0;
        step();
        check("wrap_pa", ProgAddr, 32'h00000000);
        check("wrap_pc", IfIdPC, 32'hFFFFFFFC);

        // Misaligned redirect.
        RedirectValid  = 1'b1;
        RedirectTarget = 32'h00000102;
        step();
`ifdef MISALIGN_TRAP_EN
        check("mis_trap", {31'd0, MisalignTrap}, 32'd1);
        check("mis_taddr", TrapAddr, 32'h00000102);
        check("mis_pa", ProgAddr, 32'h00000000);
`else
        check("mis_trap", {31'd0, MisalignTrap}, 32'd0);
        check("mis_taddr", TrapAddr, 32'h00000000);
        check("mis_pa", ProgAddr, 32'h00000100);
`endif
        check("mis_valid", {31'd0, IfIdValid}, 32'd0);
        RedirectValid = 1'b0;
        step();
        check("mis_trap_pulse", {31'd0, MisalignTrap}, 32'd0);

        // Asynchronous reset during CACHEWAIT.
        InsCacheStall = 1'b1;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("areset");
        InsCacheStall = 1'b0;
        #1;
        reset = 1'b0;
        step();
        check("reboot_pa", ProgAddr, 32'h00000000);
        check("reboot_valid", {31'd0, IfIdValid}, 32'd0);
        step();
        check("reboot_pc", IfIdPC, 32'h00000000);
        check("reboot_valid2", {31'd0, IfIdValid}, 32'd1);
        check("reboot_ins", IfIdIns, tag(32'h00000000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter dataW, default 32, datapath width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h00000000, first fetch address after reset.
REQ-003 SHALL have port clock  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port InsCacheStall  input  1  instruction cache refilling; fetched word invalid.
REQ-006 SHALL have port FetchIns  input  dataW  instruction returned by the instruction cache for ProgAddr.
REQ-007 SHALL have port DecodeStall  input  1  decoder cannot accept; hold the IF/ID register.
REQ-008 SHALL have port RedirectValid  input  1  taken branch/jump from execute.
REQ-009 SHALL have port RedirectTarget  input  dataW  redirect destination address.
REQ-010 SHALL have port ProgAddr  output  dataW  current fetch address to the instruction cache.
REQ-011 SHALL have port IfIdIns  output  dataW  registered instruction to the decoder.
REQ-012 SHALL have port IfIdPC  output  dataW  address of IfIdIns.
REQ-013 SHALL have port IfIdValid  output  1  IfIdIns is a real instruction, not a bubble.
REQ-014 SHALL have port MisalignTrap  output  1  one-cycle pulse on misaligned redirect.
REQ-015 SHALL have port TrapAddr  output  dataW  offending redirect target, held until the next trap.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, CACHEWAIT.
REQ-017 BOOT: entered on reset; lasts exactly one cycle; ProgAddr held; IF/ID stays a bubble; then RUN.
REQ-018 RUN -> CACHEWAIT when InsCacheStall=1; CACHEWAIT -> RUN on the first cycle InsCacheStall=0.
REQ-019 Per-cycle priority, highest first: RedirectValid, then DecodeStall, then InsCacheStall, then advance.
REQ-020 Redirect (any state except BOOT): ProgAddr <= RedirectTarget; IF/ID flushed (IfIdValid=0, IfIdIns=NOP 32'h00000013); overrides DecodeStall and InsCacheStall; FSM -> RUN.
REQ-021 DecodeStall=1 with no redirect: ProgAddr, IfIdIns, IfIdPC and IfIdValid all hold.
REQ-022 InsCacheStall=1 with no redirect and no DecodeStall: ProgAddr holds; IF/ID loads a bubble (IfIdValid=0, IfIdIns=NOP).
REQ-023 Advance (RUN, no stall, no redirect): IfIdIns <= FetchIns; IfIdPC <= ProgAddr; IfIdValid <= 1; ProgAddr <= ProgAddr+4.
REQ-024 ProgAddr+4 SHALL wrap modulo 2^dataW (32'hFFFFFFFC -> 32'h00000000) with no flag.
REQ-025 Fetch-to-IF/ID latency SHALL be exactly one cycle; throughput one instruction per cycle with no stalls.
REQ-026 The first instruction after CACHEWAIT -> RUN SHALL be the word at the held ProgAddr; no instruction is skipped or duplicated.
REQ-027 DecodeStall and InsCacheStall both high: DecodeStall rule applies (full hold); FSM still tracks InsCacheStall.

Reset
REQ-028 Reset SHALL force ProgAddr=RESET_VECTOR, IfIdIns=32'h00000013, IfIdPC=0, IfIdValid=0, MisalignTrap=0, TrapAddr=0, FSM=BOOT, regardless of clock.
REQ-029 Reset asserted mid-redirect or mid-CACHEWAIT SHALL discard all pending state; no trap is raised.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN defined: a redirect with RedirectTarget[1:0]!=0 does not update ProgAddr, flushes IF/ID, pulses MisalignTrap for one cycle, and loads TrapAddr with RedirectTarget.
REQ-031 MISALIGN_TRAP_EN undefined: RedirectTarget[1:0] is forced to 2'b00 before use; MisalignTrap and TrapAddr are tied to 0.

Verification
REQ-032 Reset, RESET_VECTOR=0, no stalls, FetchIns=addr-tagged words -> BOOT one cycle; then IfIdPC=0,4,8 consecutive with IfIdValid=1.
REQ-033 InsCacheStall high 31 cycles at ProgAddr=0x40 -> ProgAddr stays 0x40, IfIdValid=0 throughout; next cycle IfIdPC=0x40, IfIdValid=1.
REQ-034 RedirectValid with target 0x100 while DecodeStall=1 -> next cycle ProgAddr=0x100, IfIdValid=0; following cycle IfIdPC=0x100.
REQ-035 ProgAddr=0xFFFFFFFC, advance -> ProgAddr=0x00000000, IfIdPC=0xFFFFFFFC.
REQ-036 With MISALIGN_TRAP_EN, redirect to 0x102 -> MisalignTrap=1 for one cycle, TrapAddr=0x102, ProgAddr unchanged. Without the macro -> ProgAddr=0x100, MisalignTrap=0.
REQ-037 Reset asserted asynchronously during CACHEWAIT -> outputs immediately match the REQ-028 values; BOOT follows release.
